// File: rtl/mipi_dsi_pkg.sv
// Shared types, DSI data types, DCS opcodes and the panel init table
// for the DSI power-up sequencer.
package mipi_dsi_pkg;

  typedef enum logic [3:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_CMD_LOAD,
    ST_CMD_SEND,
    ST_CMD_DELAY,
    ST_VIDEO_ON,
    ST_BL_WAIT,
    ST_RUN
  } state_e;

  localparam logic [5:0] DT_DCS_SW0 = 6'h05;
  localparam logic [5:0] DT_DCS_SW1 = 6'h15;

  localparam logic [7:0] SLPOUT = 8'h11;
  localparam logic [7:0] DISPON = 8'h29;
  localparam logic [7:0] COLMOD = 8'h3A;
  localparam logic [7:0] MADCTL = 8'h36;

  typedef struct packed {
    logic       has_param;
    logic [7:0] dcs;
    logic [7:0] param;
    logic [6:0] delay_ms;
  } init_entry_t;

  // Unlisted indices decode to a zero-delay NOP write.
  function automatic logic [23:0] init_entry(input logic [5:0] idx);
    case (idx)
      6'd0:    init_entry = {1'b1, COLMOD, 8'h77, 7'd0};
      6'd1:    init_entry = {1'b1, MADCTL, 8'h00, 7'd0};
      6'd2:    init_entry = {1'b0, SLPOUT, 8'h00, 7'd120};
      6'd3:    init_entry = {1'b0, DISPON, 8'h00, 7'd20};
      default: init_entry = {1'b0, 8'h00,  8'h00, 7'd0};
    endcase
  endfunction

endpackage

// File: rtl/dsi_ms_timer.sv
// Millisecond timer: tick prescaler plus ms counter. o_done is high in the
// last cycle of the target interval (or immediately for a zero target).
module dsi_ms_timer #(
  parameter int TICKS_PER_MS = 50000,
  parameter int MS_W         = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            i_clr,
  input  logic [MS_W-1:0] i_target,
  output logic            o_done
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [TW-1:0]   r_tick;
  logic [MS_W-1:0] r_ms;
  logic            w_ms_tick;

  assign w_ms_tick = (r_tick == TW'(TICKS_PER_MS - 1));
  assign o_done    = (i_target == '0) ||
                     (w_ms_tick && (r_ms == (i_target - MS_W'(1))));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tick <= '0;
      r_ms   <= '0;
    end else if (i_clr) begin
      r_tick <= '0;
      r_ms   <= '0;
    end else if (w_ms_tick) begin
      r_tick <= '0;
      r_ms   <= r_ms + MS_W'(1);
    end else begin
      r_tick <= r_tick + TW'(1);
    end
  end

endmodule

// File: rtl/mipi_dsi_init_seq.sv
// DSI panel power-up sequencer: panel reset, DCS init writes, video enable,
// backlight. Define MIPI_DSI_BL_PWM_EN for a PWM-dimmed backlight in RUN.
module mipi_dsi_init_seq
  import mipi_dsi_pkg::*;
#(
  parameter int TICKS_PER_MS  = 50000,
  parameter int RST_LOW_MS    = 10,
  parameter int RST_WAIT_MS   = 120,
  parameter int BL_DELAY_MS   = 20,
  parameter int CMD_NUM       = 8,
  parameter int CMD_TIMEOUT   = 4096
`ifdef MIPI_DSI_BL_PWM_EN
  ,parameter int BL_PWM_PERIOD = 1000
`endif
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       reinit,
  output logic       mipi_dsi_rst_n,
  output logic       mipi_dsi_bl,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [5:0] cmd_dt,
  output logic [7:0] cmd_data0,
  output logic [7:0] cmd_data1,
  output logic       video_en,
  output logic       init_done,
`ifdef MIPI_DSI_BL_PWM_EN
  input  logic [9:0] bl_duty,
`endif
  output logic       init_err
);

  localparam int MS_W = 16;
  localparam int TO_W = $clog2(CMD_TIMEOUT + 1);

  state_e          r_state;
  logic [5:0]      r_idx;
  logic [TO_W-1:0] r_to_cnt;
  logic [6:0]      r_delay;
  logic            r_rst_n, r_bl, r_valid, r_video, r_done, r_err;
  logic [5:0]      r_dt;
  logic [7:0]      r_d0, r_d1;

  init_entry_t     w_entry;
  logic            w_timed, w_tmr_clr, w_tmr_done;
  logic [MS_W-1:0] w_target;

  assign w_entry = init_entry(r_idx);

  always_comb begin
    w_timed  = 1'b1;
    w_target = '0;
    case (r_state)
      ST_RST_LOW:   w_target = MS_W'(RST_LOW_MS);
      ST_RST_WAIT:  w_target = MS_W'(RST_WAIT_MS);
      ST_CMD_DELAY: w_target = MS_W'(r_delay);
      ST_BL_WAIT:   w_target = MS_W'(BL_DELAY_MS);
      default:      w_timed  = 1'b0;
    endcase
  end

  // Holding the timer clear outside timed states, and on every exit from one,
  // guarantees each timed state starts from zero.
  assign w_tmr_clr = reinit | w_tmr_done | ~w_timed;

  dsi_ms_timer #(.TICKS_PER_MS(TICKS_PER_MS), .MS_W(MS_W)) u_timer (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .i_clr    (w_tmr_clr),
    .i_target (w_target),
    .o_done   (w_tmr_done)
  );

`ifdef MIPI_DSI_BL_PWM_EN
  localparam int PW = (BL_PWM_PERIOD > 1) ? $clog2(BL_PWM_PERIOD) : 1;
  logic [PW-1:0] r_pwm_cnt;
  logic [PW-1:0] w_pwm_nxt;
  assign w_pwm_nxt = (r_pwm_cnt == PW'(BL_PWM_PERIOD - 1)) ? '0 : r_pwm_cnt + PW'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                r_pwm_cnt <= '0;
    else if (reinit)               r_pwm_cnt <= '0;
    else if (r_state == ST_RUN)    r_pwm_cnt <= w_pwm_nxt;
    else                           r_pwm_cnt <= '0;
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_RST_LOW;
      r_idx   <= '0;
      r_to_cnt<= '0;
      r_delay <= '0;
      r_rst_n <= 1'b0;
      r_bl    <= 1'b0;
      r_valid <= 1'b0;
      r_dt    <= '0;
      r_d0    <= '0;
      r_d1    <= '0;
      r_video <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (reinit) begin
      r_state <= ST_RST_LOW;
      r_idx   <= '0;
      r_to_cnt<= '0;
      r_delay <= '0;
      r_rst_n <= 1'b0;
      r_bl    <= 1'b0;
      r_valid <= 1'b0;
      r_dt    <= '0;
      r_d0    <= '0;
      r_d1    <= '0;
      r_video <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_RST_LOW: if (w_tmr_done) begin
          r_rst_n <= 1'b1;
          r_state <= ST_RST_WAIT;
        end
        ST_RST_WAIT: if (w_tmr_done) r_state <= ST_CMD_LOAD;
        ST_CMD_LOAD: begin
          r_dt     <= w_entry.has_param ? DT_DCS_SW1 : DT_DCS_SW0;
          r_d0     <= w_entry.dcs;
          r_d1     <= w_entry.has_param ? w_entry.param : 8'h00;
          r_delay  <= w_entry.delay_ms;
          r_to_cnt <= '0;
          r_valid  <= 1'b1;
          r_state  <= ST_CMD_SEND;
        end
        // Ready in the expiry cycle wins over the timeout.
        ST_CMD_SEND: begin
          if (cmd_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_CMD_DELAY;
          end else if (r_to_cnt == TO_W'(CMD_TIMEOUT - 1)) begin
            r_valid <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_CMD_DELAY;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_CMD_DELAY: if (w_tmr_done) begin
          if (r_idx == 6'(CMD_NUM - 1)) begin
            r_state <= ST_VIDEO_ON;
          end else begin
            r_idx   <= r_idx + 6'd1;
            r_state <= ST_CMD_LOAD;
          end
        end
        ST_VIDEO_ON: begin
          r_video <= 1'b1;
          r_state <= ST_BL_WAIT;
        end
        ST_BL_WAIT: if (w_tmr_done) begin
`ifdef MIPI_DSI_BL_PWM_EN
          r_bl    <= (bl_duty != 10'd0);
`else
          r_bl    <= 1'b1;
`endif
          r_done  <= 1'b1;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
`ifdef MIPI_DSI_BL_PWM_EN
          r_bl <= (int'(w_pwm_nxt) < int'(bl_duty));
`endif
        end
        default: r_state <= ST_RST_LOW;
      endcase
    end
  end

  assign mipi_dsi_rst_n = r_rst_n;
  assign mipi_dsi_bl    = r_bl;
  assign cmd_valid      = r_valid;
  assign cmd_dt         = r_dt;
  assign cmd_data0      = r_d0;
  assign cmd_data1      = r_d1;
  assign video_en       = r_video;
  assign init_done      = r_done;
  assign init_err       = r_err;

endmodule

// File: tb/tb_mipi_dsi_init_seq.sv
// Directed bench for mipi_dsi_init_seq with 10 ticks/ms and a 16-cycle
// command timeout; PWM checks run when MIPI_DSI_BL_PWM_EN is defined.
module tb_mipi_dsi_init_seq;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       reinit = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       mipi_dsi_rst_n, mipi_dsi_bl, cmd_valid, video_en, init_done, init_err;
  logic [5:0] cmd_dt;
  logic [7:0] cmd_data0, cmd_data1;
`ifdef MIPI_DSI_BL_PWM_EN
  logic [9:0] bl_duty = 10'd3;
`endif

  int checks = 0;
  int errors = 0;

  mipi_dsi_init_seq #(
    .TICKS_PER_MS(10), .RST_LOW_MS(10), .RST_WAIT_MS(120), .BL_DELAY_MS(20),
    .CMD_NUM(8), .CMD_TIMEOUT(16)
`ifdef MIPI_DSI_BL_PWM_EN
    ,.BL_PWM_PERIOD(10)
`endif
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .reinit(reinit),
    .mipi_dsi_rst_n(mipi_dsi_rst_n), .mipi_dsi_bl(mipi_dsi_bl),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dt(cmd_dt),
    .cmd_data0(cmd_data0), .cmd_data1(cmd_data1), .video_en(video_en),
    .init_done(init_done),
`ifdef MIPI_DSI_BL_PWM_EN
    .bl_duty(bl_duty),
`endif
    .init_err(init_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Expected {dt, d0, d1} and delay_ms per command, written out by hand.
  localparam logic [21:0] EXP_CMD [8] = '{
    {6'h15, 8'h3A, 8'h77}, {6'h15, 8'h36, 8'h00},
    {6'h05, 8'h11, 8'h00}, {6'h05, 8'h29, 8'h00},
    {6'h05, 8'h00, 8'h00}, {6'h05, 8'h00, 8'h00},
    {6'h05, 8'h00, 8'h00}, {6'h05, 8'h00, 8'h00}};
  localparam int EXP_DLY [8] = '{0, 0, 120, 20, 0, 0, 0, 0};

  // Bus monitor: valid rise/fall sample indices, data at rise, handshakes.
  int          cyc = 0;
  logic        pv = 1'b0;
  logic [21:0] held = '0;
  int          rise_q[$], fall_q[$];
  logic [21:0] rd_q[$], hs_q[$];

  always @(negedge sys_clk) begin
    cyc++;
    if (cmd_valid === 1'b1) begin
      if (pv) begin
        checks++;
        if ({cmd_dt, cmd_data0, cmd_data1} !== held) begin
          errors++;
          $display("FAIL stable_data: got %h held %h", {cmd_dt, cmd_data0, cmd_data1}, held);
        end
      end else begin
        rise_q.push_back(cyc);
        rd_q.push_back({cmd_dt, cmd_data0, cmd_data1});
      end
      held = {cmd_dt, cmd_data0, cmd_data1};
      if (cmd_ready === 1'b1) hs_q.push_back({cmd_dt, cmd_data0, cmd_data1});
    end else if (pv) begin
      fall_q.push_back(cyc);
    end
    pv = (cmd_valid === 1'b1);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_mon();
    rise_q.delete(); fall_q.delete(); rd_q.delete(); hs_q.delete();
  endtask

  task automatic wait_rst_rise(output int n);
    n = 0;
    while (mipi_dsi_rst_n !== 1'b1 && n < 1000) begin tick(); n++; end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (cmd_valid !== 1'b1 && n < 3000) begin tick(); n++; end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 10000) begin tick(); n++; end
  endtask

  task automatic restart();
    sys_rst_n = 1'b0;
    tick(2);
    clear_mon();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tick(3);
    checks++;
    if ({mipi_dsi_rst_n, mipi_dsi_bl, cmd_valid, cmd_dt, cmd_data0, cmd_data1,
         video_en, init_done, init_err} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b exp all 0",
               {mipi_dsi_rst_n, mipi_dsi_bl, cmd_valid, cmd_dt, cmd_data0, cmd_data1,
                video_en, init_done, init_err});
    end
  endtask

  task automatic test_nominal();
    int n, k, vcyc;
    cmd_ready = 1'b1;
    clear_mon();
    sys_rst_n = 1'b1;
    wait_rst_rise(n);
    checks++;
    if (n !== 100) begin errors++; $display("FAIL nom_rst_rise: got %0d exp 100", n); end
    // 1200 cycles of RST_WAIT plus the CMD_LOAD cycle.
    wait_valid(n);
    checks++;
    if (n !== 1201) begin errors++; $display("FAIL nom_first_valid: got %0d exp 1201", n); end
    checks++;
    if ({cmd_dt, cmd_data0, cmd_data1} !== 22'({6'h15, 8'h3A, 8'h77})) begin
      errors++; $display("FAIL nom_first_cmd: got %h exp %h", {cmd_dt, cmd_data0, cmd_data1}, 22'({6'h15, 8'h3A, 8'h77}));
    end
    k = 0; vcyc = -1;
    while (init_done !== 1'b1 && k < 10000) begin
      tick(); k++;
      if (video_en === 1'b1 && vcyc < 0) begin
        vcyc = k;
        checks++;
        if (mipi_dsi_bl !== 1'b0) begin errors++; $display("FAIL nom_bl_early: got %b exp 0", mipi_dsi_bl); end
      end
    end
    checks++;
    if (k - vcyc !== 200) begin errors++; $display("FAIL nom_bl_delay: got %0d exp 200", k - vcyc); end
    checks++;
    if (mipi_dsi_bl !== 1'b1 || init_err !== 1'b0) begin
      errors++; $display("FAIL nom_done_flags: bl=%b err=%b exp bl=1 err=0", mipi_dsi_bl, init_err);
    end
    checks++;
    if (hs_q.size() !== 8) begin errors++; $display("FAIL nom_hs_count: got %0d exp 8", hs_q.size()); end
    for (int i = 0; i < 8 && i < hs_q.size(); i++) begin
      checks++;
      if (hs_q[i] !== EXP_CMD[i]) begin errors++; $display("FAIL nom_cmd%0d: got %h exp %h", i, hs_q[i], EXP_CMD[i]); end
    end
    // Low gap after a command: 2 for zero delay, else delay*10 + the load cycle.
    for (int i = 0; i < 7 && i + 1 < rise_q.size() && i < fall_q.size(); i++) begin
      int eg;
      eg = (EXP_DLY[i] == 0) ? 2 : EXP_DLY[i] * 10 + 1;
      checks++;
      if (rise_q[i+1] - fall_q[i] !== eg) begin
        errors++; $display("FAIL nom_gap%0d: got %0d exp %0d", i, rise_q[i+1] - fall_q[i], eg);
      end
    end
    tick(50);
    checks++;
`ifdef MIPI_DSI_BL_PWM_EN
    if ({mipi_dsi_rst_n, cmd_valid, video_en, init_done} !== 4'b1011) begin
      errors++; $display("FAIL nom_run_hold: got %b exp 1011", {mipi_dsi_rst_n, cmd_valid, video_en, init_done});
    end
`else
    if ({mipi_dsi_rst_n, mipi_dsi_bl, cmd_valid, video_en, init_done} !== 5'b11011) begin
      errors++; $display("FAIL nom_run_hold: got %b exp 11011", {mipi_dsi_rst_n, mipi_dsi_bl, cmd_valid, video_en, init_done});
    end
`endif
  endtask

  task automatic test_ready_stall();
    int n;
    cmd_ready = 1'b1;
    restart();
    n = 0;
    while (hs_q.size() < 2 && n < 3000) begin tick(); n++; end
    cmd_ready = 1'b0;
    wait_valid(n);
    tick(5);
    cmd_ready = 1'b1;
    wait_done(n);
    checks++;
    if (rise_q.size() < 4 || fall_q.size() < 3) begin
      errors++; $display("FAIL stall_runs: got %0d rises exp 8", rise_q.size());
    end else begin
      checks++;
      if (fall_q[2] - rise_q[2] !== 6) begin errors++; $display("FAIL stall_len: got %0d exp 6", fall_q[2] - rise_q[2]); end
      checks++;
      if (rd_q[2][15:8] !== 8'h11) begin errors++; $display("FAIL stall_d0: got %h exp 11", rd_q[2][15:8]); end
      checks++;
      if (rise_q[3] - fall_q[2] !== 1201) begin errors++; $display("FAIL stall_gap: got %0d exp 1201", rise_q[3] - fall_q[2]); end
      checks++;
      if (rd_q[3][15:8] !== 8'h29) begin errors++; $display("FAIL stall_next_d0: got %h exp 29", rd_q[3][15:8]); end
    end
    checks++;
    if (init_err !== 1'b0 || init_done !== 1'b1 || hs_q.size() !== 8) begin
      errors++; $display("FAIL stall_end: err=%b done=%b hs=%0d exp 0 1 8", init_err, init_done, hs_q.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    cmd_ready = 1'b0;
    restart();
    wait_valid(n);
    checks++;
    if (init_err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b exp 0", init_err); end
    n = 0;
    while (fall_q.size() < 1 && n < 100) begin tick(); n++; end
    checks++;
    if (init_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b exp 1", init_err); end
    wait_done(n);
    checks++;
    if (init_done !== 1'b1 || rise_q.size() !== 8 || fall_q.size() !== 8 || hs_q.size() !== 0) begin
      errors++; $display("FAIL to_seq: done=%b rises=%0d falls=%0d hs=%0d exp 1 8 8 0",
                         init_done, rise_q.size(), fall_q.size(), hs_q.size());
    end
    for (int i = 0; i < 8 && i < fall_q.size() && i < rise_q.size(); i++) begin
      checks++;
      if (fall_q[i] - rise_q[i] !== 16 || rd_q[i] !== EXP_CMD[i]) begin
        errors++; $display("FAIL to_cmd%0d: len %0d data %h exp 16 %h", i, fall_q[i] - rise_q[i], rd_q[i], EXP_CMD[i]);
      end
    end
    checks++;
    if (init_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b exp 1", init_err); end
  endtask

  task automatic test_reinit();
    int n;
    // From RUN with init_err set: reinit must clear everything.
    cmd_ready = 1'b1;
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    checks++;
    if ({mipi_dsi_rst_n, mipi_dsi_bl, video_en, init_done, init_err} !== 5'd0) begin
      errors++; $display("FAIL reinit_run: got %b exp 00000", {mipi_dsi_rst_n, mipi_dsi_bl, video_en, init_done, init_err});
    end
    n = 0;
    while (!(cmd_valid === 1'b1 && cmd_data0 === 8'h36) && n < 3000) begin tick(); n++; end
    // Handshake and reinit in the same cycle: reinit wins.
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    checks++;
    if ({cmd_valid, mipi_dsi_rst_n, video_en, cmd_dt, cmd_data0, cmd_data1} !== 25'd0) begin
      errors++; $display("FAIL reinit_send: got %b exp 0",
                         {cmd_valid, mipi_dsi_rst_n, video_en, cmd_dt, cmd_data0, cmd_data1});
    end
    clear_mon();
    wait_rst_rise(n);
    checks++;
    if (n !== 100) begin errors++; $display("FAIL reinit_rst_rise: got %0d exp 100", n); end
    wait_valid(n);
    checks++;
    if (n !== 1201 || cmd_data0 !== 8'h3A) begin
      errors++; $display("FAIL reinit_first: got %0d/%h exp 1201/3a", n, cmd_data0);
    end
    wait_done(n);
    checks++;
    if (hs_q.size() !== 8) begin errors++; $display("FAIL reinit_hs_count: got %0d exp 8", hs_q.size()); end
    for (int i = 0; i < 8 && i < hs_q.size(); i++) begin
      checks++;
      if (hs_q[i] !== EXP_CMD[i]) begin errors++; $display("FAIL reinit_cmd%0d: got %h exp %h", i, hs_q[i], EXP_CMD[i]); end
    end
  endtask

  task automatic test_async_reset();
    int n;
    cmd_ready = 1'b1;
    restart();
    n = 0;
    while (!(video_en === 1'b1 && init_done === 1'b0) && n < 5000) begin tick(); n++; end
    tick(50);
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({mipi_dsi_rst_n, mipi_dsi_bl, cmd_valid, cmd_dt, cmd_data0, cmd_data1,
         video_en, init_done, init_err} !== 28'd0) begin
      errors++; $display("FAIL async_reset: got %b exp all 0",
                         {mipi_dsi_rst_n, mipi_dsi_bl, cmd_valid, cmd_dt, cmd_data0, cmd_data1,
                          video_en, init_done, init_err});
    end
    tick(2);
    clear_mon();
    sys_rst_n = 1'b1;
    wait_rst_rise(n);
    checks++;
    if (n !== 100) begin errors++; $display("FAIL async_rst_rise: got %0d exp 100", n); end
    wait_valid(n);
    checks++;
    if (n !== 1201 || cmd_data0 !== 8'h3A) begin
      errors++; $display("FAIL async_first: got %0d/%h exp 1201/3a", n, cmd_data0);
    end
    wait_done(n);
    checks++;
    if (init_done !== 1'b1 || hs_q.size() !== 8) begin
      errors++; $display("FAIL async_done: done=%b hs=%0d exp 1 8", init_done, hs_q.size());
    end
  endtask

`ifdef MIPI_DSI_BL_PWM_EN
  task automatic test_pwm();
    int hi;
    bl_duty = 10'd3;
    tick(12);
    hi = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (mipi_dsi_bl === 1'b1) hi++; end
    checks++;
    if (hi !== 9) begin errors++; $display("FAIL pwm_duty3: got %0d exp 9", hi); end
    bl_duty = 10'd0;
    tick(12);
    hi = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (mipi_dsi_bl === 1'b1) hi++; end
    checks++;
    if (hi !== 0) begin errors++; $display("FAIL pwm_duty0: got %0d exp 0", hi); end
    bl_duty = 10'd15;
    tick(12);
    hi = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (mipi_dsi_bl === 1'b1) hi++; end
    checks++;
    if (hi !== 20) begin errors++; $display("FAIL pwm_duty_full: got %0d exp 20", hi); end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_ready_stall();
    test_timeout();
    test_reinit();
    test_async_reset();
`ifdef MIPI_DSI_BL_PWM_EN
    test_pwm();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
